// File: rtl/button_pulse_conditioner.sv
// Debounces two raw pushbuttons (NEXT, SELECT) into clean one-cycle pulses and debounced levels.
// Optional NEXT auto-repeat is compiled in when AUTOREPEAT_EN is defined.
module button_pulse_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned BTN_ACTIVE_LOW  = 1
`ifdef AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_next_raw,
    input  logic btn_sel_raw,
    output logic impulso,
    output logic select,
    output logic next_lvl,
    output logic sel_lvl
);

    // state        | meaning
    // RELEASED     | debounced level 0, waiting for a pressed sample
    // PRESS_PEND   | counting stable pressed samples
    // PRESSED      | debounced level 1, press pulse already issued
    // RELEASE_PEND | counting stable released samples
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } state_t;

    localparam logic             IDLE_PIN = (BTN_ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef AUTOREPEAT_EN
    localparam int unsigned      REP_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int               REP_W      = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [REP_W-1:0] REP_DLY_M1 = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PER_M1 = REP_W'(REPEAT_PERIOD - 1);
`endif

    // index 0 = NEXT, index 1 = SELECT
    logic [1:0] w_raw;
    logic [1:0] w_pulse_d;
    logic [1:0] w_lvl;
    logic       r_impulso;
    logic       r_select;

    assign w_raw = {btn_sel_raw, btn_next_raw};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        state_t           r_state;
        state_t           w_state_nxt;
        logic             r_sync1;
        logic             r_sync2;
        logic             w_s;
        logic             r_lvl;
        logic             w_lvl_nxt;
        logic             w_press;
        logic             w_rep_hit;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic [CNT_W-1:0] w_cnt_inc;

        assign w_s       = r_sync2 ^ IDLE_PIN;
        assign w_cnt_inc = r_cnt + CNT_W'(1);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync1 <= IDLE_PIN;
                r_sync2 <= IDLE_PIN;
            end else begin
                r_sync1 <= w_raw[b];
                r_sync2 <= r_sync1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= RELEASED;
                r_cnt   <= '0;
                r_lvl   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_lvl   <= w_lvl_nxt;
            end
        end

        // The exit test uses the incremented count so the pulse lands DEBOUNCE_CYCLES+2 after the pin edge.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_lvl_nxt   = r_lvl;
            w_press     = 1'b0;
            case (r_state)
                RELEASED: begin
                    if (w_s) begin
                        w_state_nxt = PRESS_PEND;
                        w_cnt_nxt   = '0;
                    end
                end
                PRESS_PEND: begin
                    if (!w_s) begin
                        w_state_nxt = RELEASED;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc == CNT_LAST) begin
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                        w_lvl_nxt   = 1'b1;
                        w_press     = 1'b1;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!w_s) begin
                        w_state_nxt = RELEASE_PEND;
                        w_cnt_nxt   = '0;
                    end
                end
                RELEASE_PEND: begin
                    if (w_s) begin
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc == CNT_LAST) begin
                        w_state_nxt = RELEASED;
                        w_cnt_nxt   = '0;
                        w_lvl_nxt   = 1'b0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = RELEASED;
                    w_cnt_nxt   = '0;
                    w_lvl_nxt   = 1'b0;
                end
            endcase
        end

`ifdef AUTOREPEAT_EN
        localparam bit REP_EN = (b == 0);
        logic [REP_W-1:0] r_rep_cnt;
        logic             r_rep_first;

        assign w_rep_hit = REP_EN && (r_state == PRESSED) && w_s &&
                           (r_rep_cnt == (r_rep_first ? REP_DLY_M1 : REP_PER_M1));

        // Counter only advances while held in PRESSED; RELEASE_PEND leaves it frozen.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b1;
            end else if (REP_EN) begin
                if (r_state == RELEASED) begin
                    r_rep_cnt   <= '0;
                    r_rep_first <= 1'b1;
                end else if (w_rep_hit) begin
                    r_rep_cnt   <= '0;
                    r_rep_first <= 1'b0;
                end else if ((r_state == PRESSED) && w_s) begin
                    r_rep_cnt   <= r_rep_cnt + REP_W'(1);
                end
            end
        end
`else
        assign w_rep_hit = 1'b0;
`endif

        assign w_pulse_d[b] = w_press | w_rep_hit;
        assign w_lvl[b]     = r_lvl;
    end

    // SELECT wins when both pulses would fire in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_impulso <= 1'b0;
            r_select  <= 1'b0;
        end else begin
            r_impulso <= w_pulse_d[0] & ~w_pulse_d[1];
            r_select  <= w_pulse_d[1];
        end
    end

    assign impulso  = r_impulso;
    assign select   = r_select;
    assign next_lvl = w_lvl[0];
    assign sel_lvl  = w_lvl[1];

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Directed bench for button_pulse_conditioner (DEBOUNCE_CYCLES=4, active-low pins).
// Repeat expectations follow AUTOREPEAT_EN when it is defined.
module tb_button_pulse_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic btn_next_raw;
    logic btn_sel_raw;
    logic impulso;
    logic select;
    logic next_lvl;
    logic sel_lvl;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int imp_cnt = 0;
    int imp_at  = -1;
    int sel_cnt = 0;
    int sel_at  = -1;

    button_pulse_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3),
        .BTN_ACTIVE_LOW(1)
`ifdef AUTOREPEAT_EN
        ,
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_next_raw(btn_next_raw),
        .btn_sel_raw(btn_sel_raw),
        .impulso(impulso),
        .select(select),
        .next_lvl(next_lvl),
        .sel_lvl(sel_lvl)
    );

    always #5 clk = ~clk;

    // Advance one cycle and sample 1 time unit after the rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (impulso === 1'b1) begin
                imp_cnt = imp_cnt + 1;
                imp_at  = cyc;
            end
            if (select === 1'b1) begin
                sel_cnt = sel_cnt + 1;
                sel_at  = cyc;
            end
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int c;
        int ib;
        int sb;

        // 1: reset with idle pins
        reset        = 1'b1;
        btn_next_raw = 1'b1;
        btn_sel_raw  = 1'b1;
        step(3);
        check("rst_impulso", int'(impulso), 0);
        check("rst_select", int'(select), 0);
        check("rst_next_lvl", int'(next_lvl), 0);
        check("rst_sel_lvl", int'(sel_lvl), 0);
        reset = 1'b0;
        step(20);
        check("idle_imp_cnt", imp_cnt, 0);
        check("idle_sel_cnt", sel_cnt, 0);
        check("idle_next_lvl", int'(next_lvl), 0);

        // 2: clean NEXT press, then release
        c = cyc; ib = imp_cnt;
        btn_next_raw = 1'b0;
        step(5);
        check("t2_no_early_pulse", imp_cnt - ib, 0);
        check("t2_lvl_before", int'(next_lvl), 0);
        step(1);
        check("t2_impulso_c6", int'(impulso), 1);
        check("t2_lvl_c6", int'(next_lvl), 1);
        step(4);
        check("t2_one_pulse", imp_cnt - ib, 1);
        check("t2_pulse_cycle", imp_at - c, 6);
        check("t2_lvl_held", int'(next_lvl), 1);
        btn_next_raw = 1'b1;
        step(5);
        check("t2_lvl_before_fall", int'(next_lvl), 1);
        step(1);
        check("t2_lvl_fall_c6", int'(next_lvl), 0);
        step(6);
        check("t2_no_release_pulse", imp_cnt - ib, 1);

        // 3: bouncing press and bouncing release
        ib = imp_cnt;
        btn_next_raw = 1'b0; step(1);
        btn_next_raw = 1'b1; step(1);
        btn_next_raw = 1'b0; step(1);
        btn_next_raw = 1'b1; step(1);
        btn_next_raw = 1'b0;
        c = cyc;
        step(10);
        check("t3_one_pulse", imp_cnt - ib, 1);
        check("t3_pulse_cycle", imp_at - c, 6);
        btn_next_raw = 1'b1; step(1);
        btn_next_raw = 1'b0; step(1);
        btn_next_raw = 1'b1; step(1);
        btn_next_raw = 1'b0; step(1);
        btn_next_raw = 1'b1;
        step(5);
        check("t3_lvl_still_high", int'(next_lvl), 1);
        step(1);
        check("t3_lvl_fall", int'(next_lvl), 0);
        step(6);
        check("t3_no_release_pulse", imp_cnt - ib, 1);

        // 4: simultaneous presses, SELECT priority
        c = cyc; ib = imp_cnt; sb = sel_cnt;
        btn_next_raw = 1'b0;
        btn_sel_raw  = 1'b0;
        step(6);
        check("t4_select_c6", int'(select), 1);
        check("t4_impulso_c6", int'(impulso), 0);
        check("t4_sel_lvl", int'(sel_lvl), 1);
        check("t4_next_lvl", int'(next_lvl), 1);
        step(4);
        check("t4_imp_suppressed", imp_cnt - ib, 0);
        check("t4_one_select", sel_cnt - sb, 1);
        check("t4_select_cycle", sel_at - c, 6);
        btn_next_raw = 1'b1;
        btn_sel_raw  = 1'b1;
        step(12);
        check("t4_lvls_released", int'({next_lvl, sel_lvl}), 0);

        // 5: reset mid PRESS_PEND, button still held
        c = cyc; sb = sel_cnt;
        btn_sel_raw = 1'b0;
        step(3);
        reset = 1'b1;
        step(2);
        check("t5_no_pulse_before_rst", sel_cnt - sb, 0);
        check("t5_sel_lvl_in_rst", int'(sel_lvl), 0);
        reset = 1'b0;
        c = cyc;
        step(10);
        check("t5_one_select", sel_cnt - sb, 1);
        check("t5_select_cycle", sel_at - c, 6);
        btn_sel_raw = 1'b1;
        step(12);
        check("t5_sel_lvl_released", int'(sel_lvl), 0);

        // 6: long NEXT hold
        c = cyc; ib = imp_cnt;
        btn_next_raw = 1'b0;
        step(6);
        check("t6_first_pulse", int'(impulso), 1);
        step(32);
        btn_next_raw = 1'b1;
        step(15);
`ifdef AUTOREPEAT_EN
        check("t6_pulse_count", imp_cnt - ib, 6);
        check("t6_last_pulse", imp_at - c, 36);
`else
        check("t6_pulse_count", imp_cnt - ib, 1);
        check("t6_last_pulse", imp_at - c, 6);
`endif
        check("t6_lvl_released", int'(next_lvl), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
